sram_controller: RTL

- Initiator side of the 32-bit single-port asynchronous SRAM interface (`sram_we_n` / `sram_address` / `sram_dq`).
- Sits between the MEM stage and the external SRAM. Translates one-cycle-presented load/store requests into a multi-cycle SRAM access.
- Stalls the pipeline through `ready` until the access completes.
- Returns load data registered and stable during the `ready` cycle.

---
 rtl/sram_controller_pkg.sv | 15 +
 rtl/sram_addr_map.sv | 28 ++
 rtl/sram_controller.sv | 134 +++++++++++++
 3 files changed

// File: rtl/sram_controller_pkg.sv
// Shared state encoding and constants for the asynchronous SRAM controller
// and its address-map helper.
package sram_controller_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StAccess = 2'd1,
        StDone   = 2'd2
    } state_e;

    localparam logic [31:0]  DEFAULT_BASE_ADDR = 32'd1024;
    localparam int unsigned  DEFAULT_ADDR_W    = 17;
    localparam logic [31:0]  ERR_PATTERN       = 32'hDEAD_BEEF;

endpackage

// File: rtl/sram_addr_map.sv
// Combinational byte-address to SRAM word-address translation with an
// out-of-range flag (below the base address or beyond the word space).
module sram_addr_map
    import sram_controller_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = DEFAULT_BASE_ADDR,
    parameter int unsigned ADDR_W    = DEFAULT_ADDR_W
) (
    input  logic [31:0]       address_i,
    output logic [ADDR_W-1:0] word_addr_o,
    output logic              out_of_range_o
);

    logic [31:0] offset;
    logic [29:0] word_full;
    logic        unused_low;

    always_comb begin
        offset         = address_i - BASE_ADDR;
        word_full      = offset[31:2];
        word_addr_o    = word_full[ADDR_W-1:0];
        // Any word bit above the SRAM width means the index does not fit.
        out_of_range_o = (address_i < BASE_ADDR) || ((word_full >> ADDR_W) != '0);
    end

    assign unused_low = ^offset[1:0];

endmodule

// File: rtl/sram_controller.sv
// MEM-stage initiator for a 32-bit asynchronous SRAM; stalls via ready until a
// fixed-length access completes. Optional range check: SRAM_RANGE_CHECK_EN.
module sram_controller
    import sram_controller_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = 5,
    parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
    parameter int unsigned ADDR_W      = DEFAULT_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic              rd_en,
    input  logic [31:0]       address,
    input  logic [31:0]       write_data,
    output logic [31:0]       read_data,
    output logic              ready,
    output logic              error,
    output logic              sram_we_n,
    output logic [ADDR_W-1:0] sram_address,
    inout  wire  [31:0]       sram_dq
);

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              op_write_q, op_write_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              err_q, err_d;

    logic [ADDR_W-1:0] req_word;
    logic              req_oor;
    logic              req_valid;
    logic              reject;
    logic              last_cycle;
    logic              drive_bus;

    sram_addr_map #(
        .BASE_ADDR (BASE_ADDR),
        .ADDR_W    (ADDR_W)
    ) u_addr_map (
        .address_i      (address),
        .word_addr_o    (req_word),
        .out_of_range_o (req_oor)
    );

`ifdef SRAM_RANGE_CHECK_EN
    assign reject = req_oor;
`else
    logic unused_range;
    assign unused_range = req_oor;
    assign reject       = 1'b0;
`endif

    assign req_valid  = wr_en | rd_en;
    assign last_cycle = (cnt_q == 4'(WAIT_CYCLES - 1));
    assign drive_bus  = (state_q == StAccess) && op_write_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        op_write_d = op_write_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        err_d      = err_q;
        ready      = 1'b0;

        unique case (state_q)
            StIdle: begin
                ready = ~req_valid;
                if (req_valid) begin
                    if (reject) begin
                        // Skip the SRAM entirely; report through DONE.
                        state_d = StDone;
                        err_d   = 1'b1;
                        rdata_d = ERR_PATTERN;
                    end else begin
                        state_d    = StAccess;
                        cnt_d      = '0;
                        op_write_d = wr_en;
                        addr_d     = req_word;
                        wdata_d    = write_data;
                    end
                end
            end
            StAccess: begin
                cnt_d = cnt_q + 4'd1;
                if (last_cycle) begin
                    state_d = StDone;
                    if (!op_write_q) begin
                        rdata_d = sram_dq;
                    end
                end
            end
            StDone: begin
                ready   = 1'b1;
                err_d   = 1'b0;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            op_write_q <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            op_write_q <= op_write_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
        end
    end

    assign read_data    = rdata_q;
    assign error        = err_q && (state_q == StDone);
    assign sram_we_n    = ~drive_bus;
    assign sram_address = addr_q;
    assign sram_dq      = drive_bus ? wdata_q : 32'bz;

endmodule
